// File: rtl/sprite_pkg.sv
// Shared types and geometry for the sprite compositor: attribute record, FSM
// states, and the hit / address helpers used by the bank and the top level.
package sprite_pkg;
  localparam int X_MAX = 160;
  localparam int Y_MAX = 80;
  localparam int LEN   = 16384;
  localparam int XW    = $clog2(X_MAX);
  localparam int YW    = $clog2(Y_MAX);
  localparam int AW    = $clog2(LEN);
  localparam int HW    = XW + 3;

  typedef struct packed {
    logic                 en;
    logic signed [XW:0]   x;
    logic signed [YW:0]   y;
    logic [XW-1:0]        w;
    logic [XW-1:0]        h;
    logic [AW-1:0]        base;
  } spr_attr_t;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_WAIT, S_CHECK, S_WRITE
  } state_t;

  // Everything is widened to HW signed bits so sprites hanging off any edge compare correctly.
  function automatic logic spr_hit(input spr_attr_t a, input logic [XW-1:0] x,
                                   input logic [YW-1:0] y);
    logic signed [HW-1:0] xs, ys, sx, sy;
    xs = HW'(x);
    ys = HW'(y);
    sx = HW'(a.x);
    sy = HW'(a.y);
    return a.en && (xs >= sx) && (xs < sx + $signed(HW'(a.w)))
                && (ys >= sy) && (ys < sy + $signed(HW'(a.h)));
  endfunction

  function automatic logic [AW-1:0] texel_addr(input spr_attr_t a, input logic [XW-1:0] x,
                                               input logic [YW-1:0] y);
    logic signed [HW-1:0] dx, dy;
    logic [2*XW-1:0]      prod;
    dx   = HW'(x) - HW'(a.x);
    dy   = HW'(y) - HW'(a.y);
    prod = (2*XW)'(dy[XW-1:0]) * (2*XW)'(a.w);
    return a.base + AW'(prod) + AW'(dx[XW-1:0]);
  endfunction

  function automatic logic [AW-1:0] frame_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(X_MAX) + AW'(x);
  endfunction
endpackage

// File: rtl/sprite_attr_bank.sv
// Double-buffered sprite attributes: shadow set written any time, copied to the
// active set on frame_sync (held off until the compositor is idle), plus hit vector.
module sprite_attr_bank
  import sprite_pkg::*;
#(
  parameter int N_SPR = 4,
  localparam int IW   = (N_SPR > 1) ? $clog2(N_SPR) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  idle,
  input  logic                  attr_wr,
  input  logic [IW-1:0]         attr_idx,
  input  logic                  attr_en,
  input  logic [XW:0]           attr_x,
  input  logic [YW:0]           attr_y,
  input  logic [XW-1:0]         attr_w,
  input  logic [XW-1:0]         attr_h,
  input  logic [AW-1:0]         attr_base,
  input  logic                  frame_sync,
  input  logic [XW-1:0]         x,
  input  logic [YW-1:0]         y,
  output logic [N_SPR-1:0]      hit,
  output spr_attr_t [N_SPR-1:0] act
);
  spr_attr_t [N_SPR-1:0] shadow;
  spr_attr_t [N_SPR-1:0] shadow_nxt;
  logic                  commit_pend;

  // A write in the same cycle as the commit is folded into what gets committed.
  always_comb begin
    shadow_nxt = shadow;
    if (attr_wr) begin
      shadow_nxt[attr_idx] = '{en: attr_en, x: attr_x, y: attr_y,
                               w: attr_w, h: attr_h, base: attr_base};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SPR; i++) begin
        shadow[i].en <= 1'b0;
        act[i].en    <= 1'b0;
      end
      commit_pend <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      if (idle && (frame_sync || commit_pend)) begin
        act         <= shadow_nxt;
        commit_pend <= 1'b0;
      end else if (frame_sync) begin
        commit_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_SPR; i++) hit[i] = spr_hit(act[i], x, y);
  end
endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel sprite compositor: scans channels in priority order, skips
// transparent texels, writes the winner to the frame buffer and reports it.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int N_SPR              = 4,
  parameter int WIDTH              = 8,
  parameter int MEM_LAT            = 2,
  parameter logic [WIDTH-1:0] TRANSP   = '0,
  parameter logic [WIDTH-1:0] BG_COLOR = '0,
  localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [XW-1:0]     req_x,
  input  logic [YW-1:0]     req_y,
  output logic              req_ready,
  output logic              done,
  output logic [WIDTH-1:0]  done_pix,
  output logic [AW-1:0]     addr,
  output logic [WIDTH-1:0]  din,
  input  logic [WIDTH-1:0]  dout,
  output logic              we,
  input  logic              attr_wr,
  input  logic [IW-1:0]     attr_idx,
  input  logic              attr_en,
  input  logic [XW:0]       attr_x,
  input  logic [YW:0]       attr_y,
  input  logic [XW-1:0]     attr_w,
  input  logic [XW-1:0]     attr_h,
  input  logic [AW-1:0]     attr_base,
  input  logic              frame_sync,
  output logic [N_SPR-1:0]  coll,
  input  logic              coll_clr
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t                state;
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic [N_SPR-1:0]      pending;
  logic [N_SPR-1:0]      hit;
  logic [N_SPR-1:0]      cand;
  logic [N_SPR-1:0]      coll_set;
  logic [IW-1:0]         sel;
  logic [CW-1:0]         cnt;
  logic [WIDTH-1:0]      pix;
  logic                  first;
  spr_attr_t [N_SPR-1:0] act;

  sprite_attr_bank #(.N_SPR(N_SPR)) u_bank (
    .clk(clk), .rst_n(rst_n), .idle(state == S_IDLE),
    .attr_wr(attr_wr), .attr_idx(attr_idx), .attr_en(attr_en),
    .attr_x(attr_x), .attr_y(attr_y), .attr_w(attr_w), .attr_h(attr_h),
    .attr_base(attr_base), .frame_sync(frame_sync),
    .x(x_q), .y(y_q), .hit(hit), .act(act)
  );

  assign req_ready = (state == S_IDLE);
  assign cand      = pending & hit;

  always_comb begin
    sel = '0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (cand[i]) sel = IW'(i);
    end
  end

  // Bounding-box overlap with channel 0, taken once per request.
  always_comb begin
    coll_set = '0;
    if (state == S_SCAN && first) begin
      for (int i = 1; i < N_SPR; i++) coll_set[i] = hit[0] && hit[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      we       <= 1'b0;
      done     <= 1'b0;
      done_pix <= '0;
      addr     <= '0;
      din      <= '0;
      coll     <= '0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      coll <= (coll_clr ? '0 : coll) | coll_set;
      case (state)
        S_IDLE: begin
          if (req) begin
            x_q     <= req_x;
            y_q     <= req_y;
            pending <= '1;
            first   <= 1'b1;
            state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          first <= 1'b0;
          if (|cand) begin
            addr         <= texel_addr(act[sel], x_q, y_q);
            pending[sel] <= 1'b0;
            cnt          <= CW'(MEM_LAT - 1);
            state        <= S_WAIT;
          end else begin
            pix   <= BG_COLOR;
            state <= S_WRITE;
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_CHECK;
          else           cnt   <= cnt - 1'b1;
        end
        S_CHECK: begin
          if (dout != TRANSP) begin
            pix   <= dout;
            state <= S_WRITE;
          end else begin
            state <= S_SCAN;
          end
        end
        S_WRITE: begin
          addr     <= frame_addr(x_q, y_q);
          din      <= pix;
          we       <= 1'b1;
          done     <= 1'b1;
          done_pix <= pix;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: a request table over a fixed sprite scene,
// then hand-written sequences for collision, deferred commit and mid-request reset.
module tb_sprite_compositor;
  import sprite_pkg::*;

  localparam int MEM_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n, req, req_ready, done, we;
  logic [XW-1:0] req_x;
  logic [YW-1:0] req_y;
  logic [7:0]    done_pix, din, dout;
  logic [AW-1:0] addr, a1;
  logic          attr_wr, attr_en, frame_sync, coll_clr;
  logic [1:0]    attr_idx;
  logic [XW:0]   attr_x;
  logic [YW:0]   attr_y;
  logic [XW-1:0] attr_w, attr_h;
  logic [AW-1:0] attr_base;
  logic [3:0]    coll;

  always #5 clk = ~clk;

  sprite_compositor #(.N_SPR(4), .WIDTH(8), .MEM_LAT(MEM_LAT),
                      .TRANSP(8'h00), .BG_COLOR(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .done(done), .done_pix(done_pix), .addr(addr),
    .din(din), .dout(dout), .we(we), .attr_wr(attr_wr), .attr_idx(attr_idx),
    .attr_en(attr_en), .attr_x(attr_x), .attr_y(attr_y), .attr_w(attr_w),
    .attr_h(attr_h), .attr_base(attr_base), .frame_sync(frame_sync),
    .coll(coll), .coll_clr(coll_clr)
  );

  // Pixel memory: only the texels the scene needs are non-transparent.
  function automatic logic [7:0] texel(input logic [AW-1:0] a);
    case (a)
      14'd12835: return 8'h5A;
      14'd13001: return 8'h33;
      14'd13098: return 8'h77;
      14'd14045: return 8'h99;
      14'd14063: return 8'h11;
      default:   return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    a1   <= addr;
    dout <= texel(a1);
  end

  typedef struct {
    int x; int y; int pix; int lat; int rd0; int rd1;
  } vec_t;

  vec_t tbl[9];
  int   npass = 0, ncheck = 0;
  int   g_lat, g_pix, g_waddr, g_din, g_we, g_rd0, g_rd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncheck++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else npass++;
  endtask

  task automatic start_req(input int x, input int y);
    int n = 0;
    while (!req_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    req = 1'b1; req_x = XW'(x); req_y = YW'(y);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done(input int start);
    g_lat = -1; g_rd0 = -1; g_rd1 = -1;
    for (int l = start + 1; l <= 60; l++) begin
      @(posedge clk); #1;
      if (l == 1) g_rd0 = int'(addr);
      if (l == MEM_LAT + 3) g_rd1 = int'(addr);
      if (done) begin
        g_lat = l; g_pix = int'(done_pix); g_waddr = int'(addr);
        g_din = int'(din); g_we = int'(we);
        break;
      end
    end
  endtask

  task automatic do_req(input int x, input int y);
    start_req(x, y);
    wait_done(0);
  endtask

  task automatic set_attr(input int idx, input int en, input int x, input int y,
                          input int w, input int h, input int base, input int sync);
    attr_idx = 2'(idx); attr_en = en[0]; attr_x = (XW+1)'(x); attr_y = (YW+1)'(y);
    attr_w = XW'(w); attr_h = XW'(h); attr_base = AW'(base);
    attr_wr = 1'b1; frame_sync = sync[0];
    @(posedge clk); #1;
    attr_wr = 1'b0; frame_sync = 1'b0;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; req = 1'b0; req_x = '0; req_y = '0;
    attr_wr = 1'b0; attr_idx = '0; attr_en = 1'b0; attr_x = '0; attr_y = '0;
    attr_w = '0; attr_h = '0; attr_base = '0; frame_sync = 1'b0; coll_clr = 1'b0;

    tbl[0] = '{8,   22, 8'h5A, 5, 12835, -1};
    tbl[1] = '{14,  32, 8'h33, 9, 13250, 13001};
    tbl[2] = '{30,  25, 8'h77, 5, 13098, -1};
    tbl[3] = '{33,  35, 8'h00, 6, 13341, -1};
    tbl[4] = '{1,    2, 8'h99, 5, 14045, -1};
    tbl[5] = '{3,    4, 8'h11, 5, 14063, -1};
    tbl[6] = '{4,    2, 8'h00, 2, -1,    -1};
    tbl[7] = '{3,    5, 8'h00, 2, -1,    -1};
    tbl[8] = '{159, 79, 8'h00, 2, -1,    -1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_din", 32'(din), 0);
    chk("rst_done_pix", 32'(done_pix), 0);
    chk("rst_coll", 32'(coll), 0);
    rst_n = 1'b1;

    do_req(10, 10);
    chk("empty_lat", g_lat, 2);
    chk("empty_pix", g_pix, 0);
    chk("empty_waddr", g_waddr, 1610);
    chk("empty_din", g_din, 0);
    chk("empty_we", g_we, 1);

    set_attr(0, 1, 12, 24, 24, 16, 13056, 0);
    set_attr(1, 1, 5,  20, 16, 16, 12800, 0);
    set_attr(2, 1, 28, 20, 8,  8,  13568, 0);
    set_attr(3, 1, -4, -3, 8,  8,  14000, 1);

    for (int i = 0; i < 9; i++) begin
      do_req(tbl[i].x, tbl[i].y);
      chk($sformatf("v%0d_lat", i), g_lat, tbl[i].lat);
      chk($sformatf("v%0d_pix", i), g_pix, tbl[i].pix);
      chk($sformatf("v%0d_waddr", i), g_waddr, tbl[i].y * X_MAX + tbl[i].x);
      chk($sformatf("v%0d_din", i), g_din, tbl[i].pix);
      chk($sformatf("v%0d_we", i), g_we, 1);
      if (tbl[i].rd0 >= 0) chk($sformatf("v%0d_rd0", i), g_rd0, tbl[i].rd0);
      if (tbl[i].rd1 >= 0) chk($sformatf("v%0d_rd1", i), g_rd1, tbl[i].rd1);
    end
    chk("coll_after_table", 32'(coll), 32'b0110);

    coll_clr = 1'b1;
    @(posedge clk); #1;
    coll_clr = 1'b0;
    chk("coll_cleared", 32'(coll), 0);

    // Clear lands on the same edge as the new overlap: the set must survive.
    start_req(30, 25);
    coll_clr = 1'b1;
    @(posedge clk); #1;
    coll_clr = 1'b0;
    chk("coll_set_wins", 32'(coll), 32'b0100);
    wait_done(1);
    chk("coll_req_pix", g_pix, 8'h77);
    coll_clr = 1'b1;
    @(posedge clk); #1;
    coll_clr = 1'b0;
    chk("coll_cleared2", 32'(coll), 0);

    // Move channel 1 and request a commit while a pixel is in flight.
    start_req(8, 22);
    set_attr(1, 1, 50, 50, 16, 16, 12800, 0);
    frame_sync = 1'b1;
    @(posedge clk); #1;
    frame_sync = 1'b0;
    wait_done(2);
    chk("defer_lat", g_lat, 5);
    chk("defer_pix", g_pix, 8'h5A);
    do_req(8, 22);
    chk("moved_old_lat", g_lat, 2);
    chk("moved_old_pix", g_pix, 0);
    do_req(53, 52);
    chk("moved_new_lat", g_lat, 5);
    chk("moved_new_pix", g_pix, 8'h5A);
    chk("moved_new_rd0", g_rd0, 12835);

    // Reset in the middle of a texel wait.
    do_req(30, 25);
    chk("pre_rst_coll", 32'(coll), 32'b0100);
    start_req(1, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_done", 32'(done), 0);
    chk("midrst_we", 32'(we), 0);
    chk("midrst_ready", 32'(req_ready), 1);
    chk("midrst_coll", 32'(coll), 0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || we) seen++;
    end
    chk("midrst_no_write", seen, 0);
    frame_sync = 1'b1;
    @(posedge clk); #1;
    frame_sync = 1'b0;
    do_req(1, 2);
    chk("post_rst_lat", g_lat, 2);
    chk("post_rst_pix", g_pix, 0);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end
endmodule
